// File: rtl/tdm_mux_pkg.sv
// Shared constants for the time-division channel multiplexer.
package tdm_mux_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 8,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [SEL_W-1:0] k;

  // Walk offsets from farthest to nearest so the nearest hit is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = SEL_W'((int'(ptr) + i) % N);
      if (req[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end
endmodule

// File: rtl/tdm_mux_scan.sv
// Registered N-channel mux: manual select or round-robin scan over an enable mask,
// with a valid/ready output stage.
module tdm_mux_scan
  import tdm_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH*W-1:0]   ch_data,
  input  logic [N_CH-1:0]     ch_en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_ch,
  output logic                out_valid,
  input  logic                out_ready
);
  logic [N_CH-1:0][W-1:0] data_a;
  logic [SEL_W-1:0]       ptr;
  logic                   pick_found;
  logic [SEL_W-1:0]       pick_idx;
  logic [SEL_W-1:0]       src;
  logic [W-1:0]           src_word;
  logic                   sel_ok;
  logic                   load;

  assign data_a = ch_data;
  assign load   = !out_valid || out_ready;
  // sel can only exceed the channel count when N_CH is not a power of two.
  assign sel_ok = (32'(sel) < N_CH);

  rr_pick #(.N(N_CH)) u_pick (
    .req   (ch_en),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    src      = (mode == MODE_SCAN) ? pick_idx : sel;
    src_word = '0;
    for (int k = 0; k < N_CH; k++)
      if (src == SEL_W'(k)) src_word = data_a[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (load) begin
      if (mode == MODE_SCAN) begin
        if (pick_found) begin
          out_data  <= src_word;
          out_ch    <= pick_idx;
          out_valid <= 1'b1;
          ptr       <= (32'(pick_idx) == N_CH - 1) ? '0 : pick_idx + SEL_W'(1);
        end else begin
          out_valid <= 1'b0;
        end
      end else if (sel_ok) begin
        out_data  <= src_word;
        out_ch    <= sel;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/tdm_mux_scan.md
Name: tdm_mux_scan

Overview:
Parametrised, registered N-channel, W-bit multiplexer. It either follows an external select (manual mode) or autonomously round-robins over a channel-enable mask (scan mode). The block drives a single output word stream with a valid/ready handshake. It replaces the fixed 1-bit 8:1 combinational mux on paths that need time-division sampling of several channels into one downstream consumer.

Parameters:
N_CH, 8, number of input channels (2..64)
W, 8, data width per channel in bits
SEL_W, $clog2(N_CH), width of channel index (derived; do not override)

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
ch_data  in  N_CH*W  packed channel data; channel k occupies bits [k*W +: W]
ch_en  in  N_CH  scan-mode enable mask, bit k = channel k
mode  in  1  0 = manual (use sel), 1 = scan (round-robin over ch_en)
sel  in  SEL_W  manual-mode channel select
out_data  out  W  registered selected word
out_ch  out  SEL_W  channel index out_data was taken from
out_valid  out  1  out_data/out_ch valid
out_ready  in  1  downstream accepts when out_valid && out_ready

Behaviour:
- Reset (async on rst_n low): out_data=0, out_ch=0, out_valid=0, scan pointer ptr=0. Outputs stay at these values until the first rising clk after rst_n rises.
- Load enable: load = !out_valid || out_ready. Registers update only when load=1.
- Stall: while out_valid && !out_ready, out_data, out_ch, out_valid and ptr hold exactly. Input changes are ignored.
- Latency: 1 cycle from input sampled to out_valid high.
- Manual mode (mode=0), on load:
  - If sel < N_CH: out_data = ch_data[sel], out_ch = sel, out_valid = 1.
  - If sel >= N_CH (only possible when N_CH is not a power of 2): out_valid = 0, data/ch unchanged.
  - ptr is not modified in manual mode.
- Scan mode (mode=1), on load:
  - Candidate c = first index with ch_en[c]=1, searching ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1.
  - If c exists: out_data = ch_data[c], out_ch = c, out_valid = 1, ptr = (c+1) mod N_CH. Wrap from N_CH-1 goes to 0.
  - If ch_en = 0: out_valid = 0, ptr unchanged.
  - Single enabled channel: that channel is emitted every accepted cycle.
- Throughput: with out_ready held at 1, one word per cycle in both modes.
- Mode switch takes effect on the next load. ptr is retained across manual periods, so a scan resumes where it stopped.
- ch_en changes mid-scan take effect on the next load. A disabled channel already registered in out_data is still delivered.
- No combinational path from ch_data/sel/ch_en/mode to outputs.
- out_ready is used only in the load term and has no other path to outputs.

Decomposition:
- Package tdm_mux_pkg: MODE_MANUAL=1'b0, MODE_SCAN=1'b1 constants.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Parameter N.
  - Inputs: req[N], ptr[$clog2(N)].
  - Outputs: found, idx.
  - Instantiated once for the scan search; verified standalone.

Test Plan:
- Reset mid-stream: assert rst_n=0 while out_valid=1 -> out_valid, out_data, out_ch and ptr go to 0 immediately, without waiting for a clock edge.
- Manual select, N_CH=8, W=8, ch_data[k]=8'h10+k, out_ready=1, sel stepping 0..7 -> one cycle later out_data=8'h10..8'h17 with out_ch=0..7, out_valid=1 every cycle.
- Scan, ch_en=8'b1010_0101, out_ready=1 -> out_ch sequence 0,2,5,7,0,2,... with matching out_data and no gaps.
- Backpressure in scan: out_ready=0 for 3 cycles after out_ch=2 -> out_ch=2 and out_data held stable, ptr frozen; after out_ready=1 the next out_ch=5.
- Empty mask: ch_en=0 in scan -> out_valid=0 after the current word is accepted. Then set ch_en=8'h80 -> out_ch=7 repeatedly.
- Mode interleave: scan up to out_ch=2, switch to manual sel=6 for 2 words, then back to scan -> out_ch 6,6 then 5, the scan resuming from ptr=3.
- Non-power-of-2: N_CH=5, manual sel=6 -> out_valid=0; scan with all enabled wraps 0..4,0.
